// File: rtl/conf_bus_master_if.sv
// conf_bus_master_if: groups the CPU request/response handshake and the
// configuration-register bus. The master modport is the bus initiator
// (conf_bus_master). The slave modport is the CPU plus responder side.
// Only XLEN = 32 is supported.
interface conf_bus_master_if #(
    parameter int XLEN = 32
);
    // CPU request channel
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_signed;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    // CPU response channel
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    // configuration-register bus
    logic            conf_en;
    logic [3:0]      conf_wen;
    logic [XLEN-1:0] conf_addr;
    logic [XLEN-1:0] conf_wdata;
    logic [XLEN-1:0] conf_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, conf_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output conf_en, conf_wen, conf_addr, conf_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, conf_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  conf_en, conf_wen, conf_addr, conf_wdata
    );
endinterface

// File: rtl/conf_bus_master.sv
// conf_bus_master: converts one CPU load/store request into exactly one
// conf-bus access, then returns a buffered response. The block handles byte
// strobes, write-data lane replication, the responder's one-cycle read
// latency, and load extraction with sign or zero extension.
// Optional macro CONF_MASTER_ALIGN_CHECK_EN rejects misaligned half/word
// requests. When it is undefined, the offending low address bits are ignored.
module conf_bus_master #(
    parameter int XLEN = 32
) (
    input logic              clk,
    input logic              reset,      // asynchronous, active low
    conf_bus_master_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RDATA  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            sgn;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    logic [1:0]      state;
    req_t            r;
    logic [XLEN-1:0] rbuf;
    logic            ebuf;
    logic            accept;
    logic            req_bad;
    logic [3:0]      strb;
    logic [XLEN-1:0] wrep;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] ld;

    assign accept = (state == IDLE) && bus.req_valid;

    // classify the incoming request; rejected requests never touch the bus
    always_comb begin
        req_bad = (bus.req_size == 2'd3);
`ifdef CONF_MASTER_ALIGN_CHECK_EN
        if (bus.req_size == 2'd1 && bus.req_addr[0])
            req_bad = 1'b1;
        if (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0)
            req_bad = 1'b1;
`endif
    end

    // byte strobes and write-data lane replication from the registered request
    always_comb begin
        strb = 4'b1111;
        wrep = r.wdata;
        case (r.size)
            2'd0: begin
                strb = 4'b0001 << r.addr[1:0];
                wrep = {4{r.wdata[7:0]}};
            end
            2'd1: begin
                strb = r.addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{r.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // extract the addressed lane from responder data and extend it
    always_comb begin
        lane_b = 8'(bus.conf_rdata >> {r.addr[1:0], 3'b000});
        lane_h = 16'(bus.conf_rdata >> {r.addr[1], 4'b0000});
        case (r.size)
            2'd0:    ld = {{(XLEN-8){r.sgn & lane_b[7]}}, lane_b};
            2'd1:    ld = {{(XLEN-16){r.sgn & lane_h[15]}}, lane_h};
            default: ld = bus.conf_rdata;
        endcase
    end

    // request FSM and response buffer; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            r     <= '0;
            rbuf  <= '0;
            ebuf  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    r <= '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                           addr: bus.req_addr, wdata: bus.req_wdata};
                    if (req_bad) begin
                        ebuf  <= 1'b1;
                        rbuf  <= '0;
                        state <= RESP;
                    end else begin
                        state <= ACCESS;
                    end
                end
                ACCESS: state <= r.we ? RESP : RDATA;
                RDATA: begin
                    rbuf  <= ld;
                    state <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    rbuf  <= '0;
                    ebuf  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // bus outputs are driven only during the single ACCESS cycle
    assign bus.conf_en    = (state == ACCESS);
    assign bus.conf_wen   = (state == ACCESS && r.we) ? strb : 4'b0000;
    assign bus.conf_addr  = (state == ACCESS) ? r.addr : '0;
    assign bus.conf_wdata = (state == ACCESS && r.we) ? wrep : '0;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rbuf;
    assign bus.resp_err   = ebuf;
endmodule

// File: tb/tb_conf_bus_master.sv
// tb_conf_bus_master: directed vectors with hand-computed expectations.
// The conf responder returns rd_val one cycle after a read strobe.
module tb_conf_bus_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rd_val = '0;
    int          n_vec = 0;
    int          n_err = 0;

    conf_bus_master_if #(.XLEN(32)) bus ();

    conf_bus_master #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // registered-read responder
    always @(posedge clk)
        bus.conf_rdata <= (bus.conf_en && bus.conf_wen == 4'h0) ? rd_val : 32'h0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a request for one edge; returns in cycle 1 after the accept edge
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    // load with fixed latency; checks the response at cycle 3
    task automatic load_chk(input string tag, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] rd,
                            input logic [31:0] exp);
        rd_val = rd;
        issue(1'b0, size, sgn, addr, 32'h0);
        chk({tag, " en"}, 32'(bus.conf_en), 32'd1);
        chk({tag, " wen"}, 32'(bus.conf_wen), 32'h0);
        tick();
        chk({tag, " c2 valid"}, 32'(bus.resp_valid), 32'd0);
        tick();
        chk({tag, " valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, " rdata"}, bus.resp_rdata, exp);
        chk({tag, " err"}, 32'(bus.resp_err), 32'd0);
        tick();
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst conf_en", 32'(bus.conf_en), 32'd0);
        chk("rst conf_wen", 32'(bus.conf_wen), 32'h0);
        chk("rst conf_addr", bus.conf_addr, 32'h0);
        chk("rst resp_rdata", bus.resp_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // store word
        issue(1'b1, 2'd2, 1'b0, 32'hffff0000, 32'h0000a5a5);
        chk("sw en", 32'(bus.conf_en), 32'd1);
        chk("sw wen", 32'(bus.conf_wen), 32'hf);
        chk("sw wdata", bus.conf_wdata, 32'h0000a5a5);
        chk("sw addr", bus.conf_addr, 32'hffff0000);
        chk("sw ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("sw valid", 32'(bus.resp_valid), 32'd1);
        chk("sw err", 32'(bus.resp_err), 32'd0);
        chk("sw rdata", bus.resp_rdata, 32'h0);
        chk("sw c2 en", 32'(bus.conf_en), 32'd0);
        tick();
        chk("sw idle", 32'(bus.req_ready), 32'd1);

        // loads
        load_chk("lb s", 2'd0, 1'b1, 32'hffff0001, 32'h00008000, 32'hffffff80);
        load_chk("lb u", 2'd0, 1'b0, 32'hffff0001, 32'h00008000, 32'h00000080);
        load_chk("lb3 u", 2'd0, 1'b0, 32'hffff0003, 32'h7f000000, 32'h0000007f);
        load_chk("lh s", 2'd1, 1'b1, 32'hffff0002, 32'h80010000, 32'hffff8001);
        load_chk("lh u", 2'd1, 1'b0, 32'hffff0000, 32'h1234f00d, 32'h0000f00d);
        load_chk("lw", 2'd2, 1'b1, 32'hffff0004, 32'hdeadbeef, 32'hdeadbeef);

        // store half, upper lanes
        issue(1'b1, 2'd1, 1'b0, 32'hffff0002, 32'h1234beef);
        chk("sh wen", 32'(bus.conf_wen), 32'hc);
        chk("sh wdata", bus.conf_wdata, 32'hbeefbeef);
        tick();
        tick();

        // store byte, lane 3
        issue(1'b1, 2'd0, 1'b0, 32'hffff0003, 32'h1234565a);
        chk("sb wen", 32'(bus.conf_wen), 32'h8);
        chk("sb wdata", bus.conf_wdata, 32'h5a5a5a5a);
        tick();
        tick();

        // misaligned half load
`ifdef CONF_MASTER_ALIGN_CHECK_EN
        rd_val = 32'h12345678;
        issue(1'b0, 2'd1, 1'b0, 32'hffff0003, 32'h0);
        chk("mis valid", 32'(bus.resp_valid), 32'd1);
        chk("mis err", 32'(bus.resp_err), 32'd1);
        chk("mis rdata", bus.resp_rdata, 32'h0);
        chk("mis en", 32'(bus.conf_en), 32'd0);
        tick();
        chk("mis en2", 32'(bus.conf_en), 32'd0);
        chk("mis idle", 32'(bus.req_ready), 32'd1);
`else
        rd_val = 32'h12345678;
        issue(1'b0, 2'd1, 1'b0, 32'hffff0003, 32'h0);
        chk("mis addr", bus.conf_addr, 32'hffff0003);
        load_chk_tail();
`endif

        // backpressure on a load response
        bus.resp_ready = 1'b0;
        rd_val = 32'hcafef00d;
        issue(1'b0, 2'd2, 1'b0, 32'hffff0008, 32'h0);
        tick();
        tick();
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'hffff000c;
        bus.req_wdata = 32'h11223344;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", 32'(bus.resp_valid), 32'd1);
            chk("bp rdata", bus.resp_rdata, 32'hcafef00d);
            chk("bp err", 32'(bus.resp_err), 32'd0);
            chk("bp ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        chk("bp idle ready", 32'(bus.req_ready), 32'd1);
        chk("bp idle en", 32'(bus.conf_en), 32'd0);
        chk("bp idle valid", 32'(bus.resp_valid), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        chk("bp next en", 32'(bus.conf_en), 32'd1);
        chk("bp next addr", bus.conf_addr, 32'hffff000c);
        tick();
        tick();

        // reserved size
        issue(1'b1, 2'd3, 1'b0, 32'hffff0000, 32'hffffffff);
        chk("sz3 valid", 32'(bus.resp_valid), 32'd1);
        chk("sz3 err", 32'(bus.resp_err), 32'd1);
        chk("sz3 en", 32'(bus.conf_en), 32'd0);
        chk("sz3 wen", 32'(bus.conf_wen), 32'h0);
        tick();
        chk("sz3 en2", 32'(bus.conf_en), 32'd0);

        // reset during ACCESS
        rd_val = 32'h55555555;
        issue(1'b0, 2'd2, 1'b0, 32'hffff0010, 32'h0);
        chk("rs pre en", 32'(bus.conf_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs en", 32'(bus.conf_en), 32'd0);
        chk("rs ready", 32'(bus.req_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rs valid", 32'(bus.resp_valid), 32'd0);
            chk("rs idle", 32'(bus.req_ready), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // tail of the unchecked misaligned half load: addr[1]=1 selects upper half
    task automatic load_chk_tail();
        chk("mis en", 32'(bus.conf_en), 32'd1);
        chk("mis wen", 32'(bus.conf_wen), 32'h0);
        tick();
        tick();
        chk("mis valid", 32'(bus.resp_valid), 32'd1);
        chk("mis err", 32'(bus.resp_err), 32'd0);
        chk("mis rdata", bus.resp_rdata, 32'h00001234);
        tick();
    endtask
endmodule

// File: doc/conf_bus_master.md
Name: conf_bus_master

Overview:
- Initiator for the CPU configuration-register bus (conf_en / conf_wen / conf_addr / conf_wdata / conf_rdata).
- Drives peripheral register blocks such as LED/segment confreg.
- Converts a CPU-side valid/ready load/store request into exactly one conf-bus access and returns a buffered response.
- Handles byte-lane strobes, write-data replication, the responder's one-cycle registered read latency, and load extraction/extension.

Parameters:
- XLEN, 32, data and address width (fixed by `XLEN; only 32 supported).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- req_valid  input  1  CPU request valid.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 byte, 1 halfword, 2 word, 3 reserved.
- req_signed  input  1  load sign-extension select.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response valid.
- resp_ready  input  1  CPU accepts response.
- resp_rdata  output  32  load data, extended; 0 for stores and errors.
- resp_err  output  1  request rejected, no bus access made.
- conf_en  output  1  bus access strobe, one cycle per access.
- conf_wen  output  4  byte write enables; 0 for reads.
- conf_addr  output  32  access address.
- conf_wdata  output  32  lane-replicated write data.
- conf_rdata  input  32  responder read data, valid the cycle after conf_en.

Behaviour:
- States: IDLE, ACCESS, RDATA, RESP. Reset enters IDLE.
- Reset values: req_ready=1; all other outputs 0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register the request.
  - Next state is ACCESS, or RESP with err=1 for an error request.
- ACCESS (exactly one cycle):
  - conf_en=1 and conf_addr=registered req_addr, unmodified.
  - Store: conf_wen = strobe and conf_wdata = replicated data; next RESP.
  - Load: conf_wen=0, conf_wdata=0; next RDATA.
- RDATA: conf_en=0; capture conf_rdata into the response buffer; next RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable while resp_ready=0.
  - On resp_ready, go to IDLE and clear the buffer.
- Outside ACCESS: conf_en, conf_wen, conf_addr and conf_wdata are all 0.
- Latency from the accept edge:
  - store: conf_en at cycle 1, resp_valid at cycle 2;
  - load: conf_en at cycle 1, resp_valid at cycle 3;
  - error: resp_valid at cycle 1.
- Strobes:
  - byte: 1<<addr[1:0];
  - half: 4'b0011 if addr[1]=0, else 4'b1100;
  - word: 4'b1111.
- Write data replication: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as-is.
- Load extraction:
  - byte: conf_rdata >> (8*addr[1:0]), low 8 bits.
  - half: conf_rdata >> (16*addr[1]), low 16 bits.
  - Sign-extend if req_signed, else zero-extend. Word loads pass through.
- Error requests: req_size=3 is always an error; misalignment is an error per the optional feature. Errors never assert conf_en.
- Only one outstanding request; req_ready=0 in every state except IDLE.
- Reset asserted mid-transaction:
  - immediate (asynchronous) return to IDLE;
  - conf_en deasserts without waiting for the clock;
  - the pending response is discarded and never presented.
- req_valid may drop before acceptance; no request is registered unless the handshake completes.

Optional Feature:
- Macro: CONF_MASTER_ALIGN_CHECK_EN.
- Defined:
  - halfword with addr[0]=1 is an error;
  - word with addr[1:0]!=0 is an error.
  - resp_err=1, resp_rdata=0, no bus access.
- Undefined:
  - alignment is not checked; offending low address bits are ignored for strobe/extraction;
  - halfword uses addr[1] only; word uses 4'b1111 and no shift;
  - conf_addr is still the unmodified address.
  - Only req_size=3 produces resp_err.

Test Plan:
- Store word, addr 0xffff0000, wdata 0x0000a5a5, resp_ready=1 -> at cycle 1: conf_en=1, conf_wen=4'hf, conf_wdata=0x0000a5a5, conf_addr=0xffff0000. At cycle 2: resp_valid=1, resp_err=0, resp_rdata=0.
- Signed byte load, addr 0xffff0001, conf_rdata=0x00008000 at cycle 2 -> conf_wen=0 at cycle 1; at cycle 3: resp_rdata=0xffffff80. Same load with req_signed=0 -> resp_rdata=0x00000080.
- Store half, addr 0xffff0002, wdata 0x1234beef -> conf_wen=4'b1100, conf_wdata=0xbeefbeef.
- With CONF_MASTER_ALIGN_CHECK_EN, half load at addr 0xffff0003 -> resp_valid at cycle 1 with resp_err=1, resp_rdata=0, conf_en never 1. Without the macro, same request -> conf_en=1, conf_wen=0, normal response.
- Backpressure: resp_ready=0 for 5 cycles after a load -> resp_valid, resp_rdata, resp_err stable; req_ready=0 with req_valid held; the next request is accepted only in the cycle after resp_ready=1.
- req_size=3 -> resp_err=1, no bus access. Reset pulled low during ACCESS -> conf_en=0 immediately; after release req_ready=1 and resp_valid stays 0.
